spi_ram_burst: RTL



---
 rtl/spi_ram_pkg.sv | 15 +
 rtl/spi_ram_mem.sv | 52 +++++
 rtl/spi_ram_burst.sv | 106 ++++++++++
 3 files changed

// File: rtl/spi_ram_pkg.sv
// Shared opcode encoding and helpers for the command-decoded SPI RAM.
package spi_ram_pkg;

   typedef enum logic [1:0] {
      OP_SET_WR  = 2'b00,
      OP_WR_DATA = 2'b01,
      OP_SET_RD  = 2'b10,
      OP_RD_DATA = 2'b11
   } spi_op_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// DEPTH x DATA_W RAM: one synchronous write port, one registered read port.
// Define SPI_RAM_MEM_INIT_EN to load mem[i] = i on reset assertion.
module spi_ram_mem #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

`ifdef SPI_RAM_MEM_INIT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= DATA_W'(i);
         end
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end
`else
   // No reset on the array so it can map onto block RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end
`endif

   // Output register holds its value between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (re) begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram_burst.sv
// Command-decoded burst RAM between an SPI slave deserialiser and its transmit serialiser.
// Optional build macro: SPI_RAM_MEM_INIT_EN (memory loads mem[i] = i on reset).
module spi_ram_burst
   import spi_ram_pkg::*;
#(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8,
   localparam int unsigned PAY_W = max_u(ADDR_W, DATA_W)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [PAY_W+1:0]   din,
   input  logic               rx_valid,
   output logic [DATA_W-1:0]  dout,
   output logic               tx_valid,
   output logic               err
);

   spi_op_e           op;
   logic [PAY_W-1:0]  payload;

   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              wr_armed_q, wr_armed_d;
   logic              rd_armed_q, rd_armed_d;
   logic              tx_valid_q, err_q, err_d;
   logic              mem_we, mem_re;

   assign op      = spi_op_e'(din[PAY_W+1:PAY_W]);
   assign payload = din[PAY_W-1:0];

   always_comb begin
      wr_addr_d  = wr_addr_q;
      rd_addr_d  = rd_addr_q;
      wr_armed_d = wr_armed_q;
      rd_armed_d = rd_armed_q;
      err_d      = 1'b0;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      if (rx_valid) begin
         unique case (op)
            OP_SET_WR: begin
               wr_addr_d  = payload[ADDR_W-1:0];
               wr_armed_d = 1'b1;
            end
            OP_WR_DATA: begin
               if (wr_armed_q) begin
                  mem_we    = 1'b1;
                  wr_addr_d = wr_addr_q + ADDR_W'(1);
               end else begin
                  err_d = 1'b1;
               end
            end
            OP_SET_RD: begin
               rd_addr_d  = payload[ADDR_W-1:0];
               rd_armed_d = 1'b1;
            end
            OP_RD_DATA: begin
               if (rd_armed_q) begin
                  mem_re    = 1'b1;
                  rd_addr_d = rd_addr_q + ADDR_W'(1);
               end else begin
                  err_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr_q  <= '0;
         rd_addr_q  <= '0;
         wr_armed_q <= 1'b0;
         rd_armed_q <= 1'b0;
         tx_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         wr_addr_q  <= wr_addr_d;
         rd_addr_q  <= rd_addr_d;
         wr_armed_q <= wr_armed_d;
         rd_armed_q <= rd_armed_d;
         tx_valid_q <= mem_re;
         err_q      <= err_d;
      end
   end

   spi_ram_mem #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (mem_we),
      .waddr (wr_addr_q),
      .wdata (payload[DATA_W-1:0]),
      .re    (mem_re),
      .raddr (rd_addr_q),
      .rdata (dout)
   );

   assign tx_valid = tx_valid_q;
   assign err      = err_q;

endmodule
